multu_hilo_ctrl: RTL and testbench
==================================

Name: multu_hilo_ctrl

Overview:
- Multi-cycle sequencer for the unsigned multiply (MULTU) path feeding the HiLo register.
- Runs a 32-iteration shift-add multiply on operands issued from EX.
- Writes the 64-bit product, or an MTHI/MTLO value, into HiLo through a write enable.
- Raises a pipeline stall whenever an instruction needs HiLo or the multiplier while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH; iteration count equals WIDTH.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  MULTU in EX; requests a multiply of SrcA*SrcB.
- SrcA  input  WIDTH  multiplicand, unsigned.
- SrcB  input  WIDTH  multiplier, unsigned.
- MfReq  input  1  MFHI/MFLO in EX.
- MfSel  input  1  1 = Hi, 0 = Lo (for MfReq).
- MtReq  input  1  MTHI/MTLO in EX.
- MtSel  input  1  1 = Hi, 0 = Lo (for MtReq).
- MtData  input  WIDTH  value to write for MTHI/MTLO.
- HiIn  input  WIDTH  current HiOut of HiLo.
- LoIn  input  WIDTH  current LoOut of HiLo.
- HiLoWe  output  1  HiLo load enable; HiLo loads HiLoData only when high.
- HiLoData  output  2*WIDTH  value to load into HiLo (drives its MultuAns).
- MfData  output  WIDTH  MFHI/MFLO result: MfSel ? HiIn : LoIn, combinational.
- Busy  output  1  high in RUN and DONE.
- Stall  output  1  freeze IF/ID/EX; the instruction in EX is re-presented next cycle.

Behaviour:
- States: IDLE, RUN, DONE. Internal registers: mcand (2*WIDTH), mplier (WIDTH), acc (2*WIDTH), cnt (log2 WIDTH bits).
- Reset, sampled at posedge:
  - state = IDLE; mcand, mplier, acc, cnt = 0.
  - Outputs after reset: HiLoWe = 0, HiLoData = 0, Busy = 0, Stall = 0.
  - MfData follows HiIn/LoIn; this block does not reset HiLo itself.
- IDLE, Start = 1:
  - mcand = zero-extended SrcA; mplier = SrcB; acc = 0; cnt = 0; go to RUN.
  - No Stall.
- RUN, each cycle:
  - If mplier[0], acc = acc + mcand, with 2*WIDTH wrap (never overflows for unsigned operands).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt == WIDTH-1 at the edge, go to DONE. RUN lasts exactly WIDTH cycles; there is no early termination.
- DONE, one cycle:
  - HiLoWe = 1, HiLoData = acc; go to IDLE. HiLo holds the product after that edge.
- Latency: Start sampled at edge E0; HiLoWe high in the cycle after E32; HiLo updated at E33. Busy is high for WIDTH+1 = 33 cycles.
- IDLE, MtReq = 1 and Start = 0:
  - HiLoWe = 1 in the same cycle (combinational).
  - HiLoData = MtSel ? {MtData, LoIn} : {HiIn, MtData}.
  - No Stall.
- HiLoWe and HiLoData are 0 in all other cycles.
- Stall = Busy & (Start | MfReq | MtReq). Start is never accepted while Busy; the multiply in flight is not disturbed.
- MfReq in DONE stalls, because HiLo is not updated until the end of DONE. MfReq in IDLE never stalls.
- Start and MtReq together in IDLE cannot come from a legal pipeline. Start wins; the Mt write is dropped.
- Reset mid-RUN/DONE: next state is IDLE; no HiLoWe pulse; the partial product is discarded.
- Reset has priority over all requests in the same cycle.

Test Plan:
1. Assert Reset for 2 cycles with Start = 1 -> Busy = 0, Stall = 0, HiLoWe = 0, HiLoData = 0; no multiply starts.
2. Start with SrcA = 3, SrcB = 5 -> Busy high 33 cycles; HiLoWe pulse exactly in cycle 33 after the Start edge; HiLoData = 64'h0000000F.
3. Start with SrcA = SrcB = 32'hFFFFFFFF -> HiLoData = 64'hFFFFFFFE00000001; a second case with SrcB = 0 gives 0.
4. MfReq = 1, MfSel = 1, held from RUN cycle 5 -> Stall high through the DONE cycle, low the next cycle; MfData = new Hi (e.g. 32'h00000001 for 32'h80000000 * 2).
5. IDLE with LoIn = 32'h00001234, MtReq = 1, MtSel = 1, MtData = 32'hDEADBEEF -> same-cycle HiLoWe = 1, HiLoData = 64'hDEADBEEF00001234, Stall = 0.
6. Reset at RUN cycle 10 -> IDLE next cycle with no HiLoWe pulse; a fresh Start (7 * 6) then yields HiLoData = 42 after 33 cycles. Also check Start while Busy -> Stall = 1 and the first result is unchanged.

Source files
------------

// File: rtl/multu_hilo_ctrl.sv
// MULTU sequencer: 32-step shift-add multiply into HiLo, MTHI/MTLO writes,
// MFHI/MFLO read mux, and pipeline stall while the multiplier is in flight.
module multu_hilo_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   SrcA,
    input  logic [WIDTH-1:0]   SrcB,
    input  logic               MfReq,
    input  logic               MfSel,
    input  logic               MtReq,
    input  logic               MtSel,
    input  logic [WIDTH-1:0]   MtData,
    input  logic [WIDTH-1:0]   HiIn,
    input  logic [WIDTH-1:0]   LoIn,
    output logic               HiLoWe,
    output logic [2*WIDTH-1:0] HiLoData,
    output logic [WIDTH-1:0]   MfData,
    output logic               Busy,
    output logic               Stall
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] mcand, mcand_next;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   mplier, mplier_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic               mt_write;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            acc    <= acc_next;
            cnt    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        acc_next    = acc;
        cnt_next    = cnt;
        case (state)
            IDLE: begin
                if (Start) begin
                    mcand_next  = {{WIDTH{1'b0}}, SrcA};
                    mplier_next = SrcB;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (mplier[0]) acc_next = acc + mcand;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + CW'(1);
                if (cnt == LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Start outranks a simultaneous MT*, and Reset suppresses any HiLo write.
    always_comb begin
        Busy     = (state != IDLE);
        mt_write = (state == IDLE) && MtReq && !Start;
        HiLoWe   = 1'b0;
        HiLoData = '0;
        if (!Reset) begin
            if (state == DONE) begin
                HiLoWe   = 1'b1;
                HiLoData = acc;
            end else if (mt_write) begin
                HiLoWe   = 1'b1;
                HiLoData = MtSel ? {MtData, LoIn} : {HiIn, MtData};
            end
        end
        Stall  = Busy && (Start || MfReq || MtReq);
        MfData = MfSel ? HiIn : LoIn;
    end

endmodule

// File: tb/tb_multu_hilo_ctrl.sv
// Bench for multu_hilo_ctrl: cycle-count reference model of the multiply
// sequencer plus a HiLo register, directed literal cases and random traffic.
module tb_multu_hilo_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b1;
    logic [31:0] SrcA = 32'd3, SrcB = 32'd5;
    logic        MfReq = 1'b0, MfSel = 1'b0, MtReq = 1'b0, MtSel = 1'b0;
    logic [31:0] MtData = '0;
    logic [31:0] HiIn, LoIn;
    logic        HiLoWe;
    logic [63:0] HiLoData;
    logic [31:0] MfData;
    logic        Busy, Stall;

    multu_hilo_ctrl #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .SrcA(SrcA), .SrcB(SrcB),
        .MfReq(MfReq), .MfSel(MfSel), .MtReq(MtReq), .MtSel(MtSel),
        .MtData(MtData), .HiIn(HiIn), .LoIn(LoIn), .HiLoWe(HiLoWe),
        .HiLoData(HiLoData), .MfData(MfData), .Busy(Busy), .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    // HiLo register of the surrounding pipeline, loaded from the DUT
    logic [63:0] hilo = '0;
    always @(posedge Clk) if (HiLoWe) hilo <= HiLoData;
    assign HiIn = hilo[63:32];
    assign LoIn = hilo[31:0];

    // Reference model: m_cnt = 0 idle, 1..32 multiplying, 33 writing product
    int          m_cnt = 0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_hilo = '0;
    logic [63:0] a64, b64;
    assign a64 = {32'd0, SrcA};
    assign b64 = {32'd0, SrcB};

    always @(posedge Clk) begin
        if (Reset) begin
            m_cnt <= 0;
        end else if (m_cnt == 0) begin
            if (Start) begin
                m_cnt  <= 1;
                m_prod <= a64 * b64;
            end else if (MtReq) begin
                if (MtSel) m_hilo[63:32] <= MtData;
                else       m_hilo[31:0]  <= MtData;
            end
        end else if (m_cnt == 33) begin
            m_cnt  <= 0;
            m_hilo <= m_prod;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            logic        e_busy, e_mt, e_we, e_stall;
            logic [63:0] e_data;
            e_busy  = (m_cnt != 0);
            e_mt    = (m_cnt == 0) && MtReq && !Start;
            e_we    = !Reset && ((m_cnt == 33) || e_mt);
            e_data  = '0;
            if (!Reset && m_cnt == 33) e_data = m_prod;
            else if (!Reset && e_mt)   e_data = MtSel ? {MtData, m_hilo[31:0]} : {m_hilo[63:32], MtData};
            e_stall = e_busy && (Start || MfReq || MtReq);
            chk("busy", 64'(Busy), 64'(e_busy));
            chk("hilowe", 64'(HiLoWe), 64'(e_we));
            chk("hilodata", HiLoData, e_data);
            chk("stall", 64'(Stall), 64'(e_stall));
            chk("mfdata", 64'(MfData), 64'(MfSel ? m_hilo[63:32] : m_hilo[31:0]));
            chk("hilo_reg", hilo, m_hilo);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Reset = 0; Start = 0; MfReq = 0; MfSel = 0; MtReq = 0; MtSel = 0; MtData = '0;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge Clk);
            if (!Busy) seen = 1'b1;
            @(posedge Clk);
            #1;
        end
        chk({tag, "_idle_timeout"}, 64'(seen), 64'd1);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string tag);
        int          busy_cycles = 0;
        int          we_at = -1;
        logic [63:0] cap = '0;
        SrcA = a; SrcB = b; Start = 1;
        tick();
        Start = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (Busy) busy_cycles++;
            if (HiLoWe && we_at < 0) begin
                we_at = i;
                cap   = HiLoData;
            end
        end
        @(posedge Clk);
        #1;
        chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        chk({tag, "_we_cycle"}, 64'(we_at), 64'd33);
        chk({tag, "_product"}, cap, exp);
        chk({tag, "_hilo"}, hilo, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          last_stall;
        logic [31:0] mf34;

        // Reset held with Start high: nothing may start
        tick();
        chk_en = 1'b1;
        tick();
        clear_inputs();
        @(negedge Clk);
        chk("t1_busy", 64'(Busy), 64'd0);
        chk("t1_stall", 64'(Stall), 64'd0);
        chk("t1_we", 64'(HiLoWe), 64'd0);
        chk("t1_data", HiLoData, 64'd0);
        @(posedge Clk);
        #1;

        run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, "t2");
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "t3max");
        run_mul(32'hFFFFFFFF, 32'd0, 64'd0, "t3zero");

        // MFHI held from RUN cycle 5: stall through DONE, then new Hi visible
        SrcA = 32'h80000000; SrcB = 32'd2; Start = 1;
        tick();
        Start = 0;
        repeat (4) tick();
        MfReq = 1; MfSel = 1;
        last_stall = 0;
        mf34 = '0;
        for (int i = 5; i <= 36; i++) begin
            @(negedge Clk);
            if (Stall) last_stall = i;
            if (i == 34) mf34 = MfData;
            @(posedge Clk);
            #1;
        end
        MfReq = 0;
        chk("t4_last_stall", 64'(last_stall), 64'd33);
        chk("t4_mfdata", 64'(mf34), 64'h1);

        // MTLO then MTHI in IDLE, same-cycle write
        MtReq = 1; MtSel = 0; MtData = 32'h00001234;
        tick();
        MtSel = 1; MtData = 32'hDEADBEEF;
        @(negedge Clk);
        chk("t5_we", 64'(HiLoWe), 64'd1);
        chk("t5_data", HiLoData, 64'hDEADBEEF00001234);
        chk("t5_stall", 64'(Stall), 64'd0);
        @(posedge Clk);
        #1;
        clear_inputs();

        // Reset at RUN cycle 10 discards the product
        SrcA = 32'd1000; SrcB = 32'd1000; Start = 1;
        tick();
        Start = 0;
        repeat (9) tick();
        Reset = 1;
        tick();
        Reset = 0;
        @(negedge Clk);
        chk("t6_busy_after_reset", 64'(Busy), 64'd0);
        chk("t6_we_after_reset", 64'(HiLoWe), 64'd0);
        @(posedge Clk);
        #1;
        chk("t6_hilo_kept", hilo, 64'hDEADBEEF00001234);
        run_mul(32'd7, 32'd6, 64'd42, "t6fresh");

        // Start while busy stalls and leaves the in-flight result alone
        SrcA = 32'd9; SrcB = 32'd9; Start = 1;
        tick();
        Start = 0;
        repeat (2) tick();
        SrcA = 32'd100; SrcB = 32'd100; Start = 1;
        @(negedge Clk);
        chk("t6_start_busy_stall", 64'(Stall), 64'd1);
        @(posedge Clk);
        #1;
        Start = 0;
        wait_idle(40, "t6");
        chk("t6_first_result", hilo, 64'd81);

        // Random traffic against the model
        for (int t = 0; t < 30; t++) begin
            SrcA = pick(); SrcB = pick(); Start = 1;
            tick();
            for (int c = 0; c < 40; c++) begin
                Start  = ($urandom_range(0, 7) == 0);
                SrcA   = pick();
                SrcB   = pick();
                MfReq  = $urandom_range(0, 1);
                MfSel  = $urandom_range(0, 1);
                MtReq  = ($urandom_range(0, 3) == 0);
                MtSel  = $urandom_range(0, 1);
                MtData = $urandom;
                Reset  = ($urandom_range(0, 299) == 0);
                tick();
            end
            clear_inputs();
            tick();
        end
        wait_idle(40, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
